// File: rtl/cpu_types.sv
// Types shared across the CPU: memory access sizes plus the memory arbiter's
// FSM state and port encodings.
package cpu_types;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } memory_mask_t;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        BUSY_INSTR = 2'd1,
        BUSY_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_INSTR = 1'b0,
        ARB_DATA  = 1'b1
    } arb_port_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Memory-response watchdog: counts stalled BUSY cycles and flags the one in
// which the TIMEOUT-th stalled cycle is reached. TIMEOUT = 0 disables it.
module mem_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expired = 1'b0;
        end else begin : g_enabled
            localparam int W = $clog2(TIMEOUT + 1);
            localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

            logic [W-1:0] r_count;

            always_ff @(posedge clk) begin
                if (rst || clear) begin
                    r_count <= '0;
                end else if (enable) begin
                    r_count <= r_count + 1'b1;
                end
            end

            // r_count holds the cycles already elapsed, so the current cycle is r_count+1.
            assign expired = enable && (r_count == LAST);
        end
    endgenerate

endmodule

// File: rtl/memory_arbiter.sv
// Shares the single-ported memory between instruction fetch and load/store,
// one registered transaction at a time, round-robin on ties.
module memory_arbiter
    import cpu_types::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_req,
    input  logic [31:0]  instr_addr,
    output logic         instr_ack,
    output logic [31:0]  instr_rdata,
    output logic         instr_err,
    input  logic         data_req,
    input  logic [31:0]  data_addr,
    input  logic         data_we,
    input  logic [31:0]  data_wdata,
    input  memory_mask_t data_mask,
    output logic         data_ack,
    output logic [31:0]  data_rdata,
    output logic         data_err,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    output logic         mem_we,
    output logic [31:0]  mem_wdata,
    output memory_mask_t mem_mask,
    input  logic         mem_ready,
    input  logic [31:0]  mem_rdata
);

    arb_state_t   r_state;
    arb_state_t   w_next_state;
    arb_port_t    r_last_grant;
    logic         r_mem_req;
    logic [31:0]  r_mem_addr;
    logic         r_mem_we;
    logic [31:0]  r_mem_wdata;
    memory_mask_t r_mem_mask;

    logic w_grant_instr;
    logic w_grant_data;
    logic w_done;
    logic w_timeout;
    logic w_expired;
    logic w_ack_ok;

    mem_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_grant_instr || w_grant_data),
        .enable ((r_state != IDLE) && !mem_ready),
        .expired(w_expired)
    );

    always_comb begin
        w_next_state  = r_state;
        w_grant_instr = 1'b0;
        w_grant_data  = 1'b0;
        w_done        = 1'b0;
        w_timeout     = 1'b0;
        unique case (r_state)
            IDLE: begin
                // On a tie the port that was not granted last time wins.
                if (data_req && (!instr_req || r_last_grant == ARB_INSTR)) begin
                    w_grant_data = 1'b1;
                    w_next_state = BUSY_DATA;
                end else if (instr_req) begin
                    w_grant_instr = 1'b1;
                    w_next_state  = BUSY_INSTR;
                end
            end
            BUSY_INSTR, BUSY_DATA: begin
                if (mem_ready) begin
                    w_done       = 1'b1;
                    w_next_state = IDLE;
                end else if (w_expired) begin
                    w_done       = 1'b1;
                    w_timeout    = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= ARB_INSTR;
        end else begin
            r_state <= w_next_state;
            if (w_grant_data) begin
                r_last_grant <= ARB_DATA;
            end else if (w_grant_instr) begin
                r_last_grant <= ARB_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_mask  <= MEM_BYTE;
        end else if (w_grant_data) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= data_addr;
            r_mem_we    <= data_we;
            r_mem_wdata <= data_wdata;
            r_mem_mask  <= data_mask;
        end else if (w_grant_instr) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= instr_addr;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_mask  <= MEM_WORD;
        end else if (w_done) begin
            r_mem_req <= 1'b0;
        end
    end

    // Reset abandons an in-flight transaction, so completions are masked while it is high.
    assign w_ack_ok    = w_done && !rst;
    assign instr_ack   = w_ack_ok && (r_state == BUSY_INSTR);
    assign data_ack    = w_ack_ok && (r_state == BUSY_DATA);
    assign instr_err   = instr_ack && w_timeout;
    assign data_err    = data_ack && w_timeout;
    assign instr_rdata = (instr_ack && !w_timeout) ? mem_rdata : '0;
    assign data_rdata  = (data_ack && !w_timeout) ? mem_rdata : '0;

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign mem_mask  = r_mem_mask;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of the arbitration and completion rules.
module tb_memory_arbiter;
    import cpu_types::*;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         instr_req = 1'b0;
    logic [31:0]  instr_addr = '0;
    logic         instr_ack;
    logic [31:0]  instr_rdata;
    logic         instr_err;
    logic         data_req = 1'b0;
    logic [31:0]  data_addr = '0;
    logic         data_we = 1'b0;
    logic [31:0]  data_wdata = '0;
    memory_mask_t data_mask = MEM_WORD;
    logic         data_ack;
    logic [31:0]  data_rdata;
    logic         data_err;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_we;
    logic [31:0]  mem_wdata;
    memory_mask_t mem_mask;
    logic         mem_ready = 1'b0;
    logic [31:0]  mem_rdata = '0;

    int n_checks = 0;
    int n_fail = 0;
    int mem_lat = 1;
    int busy_cyc = 0;

    memory_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_ack(instr_ack),
        .instr_rdata(instr_rdata), .instr_err(instr_err),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we),
        .data_wdata(data_wdata), .data_mask(data_mask), .data_ack(data_ack),
        .data_rdata(data_rdata), .data_err(data_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model: answers in the mem_lat-th cycle of mem_req (0 = never).
    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1) busy_cyc = busy_cyc + 1;
        else busy_cyc = 0;
        if (mem_req === 1'b1 && mem_lat != 0 && busy_cyc == mem_lat) begin
            mem_ready = 1'b1;
            mem_rdata = rd_fn(mem_addr);
        end else begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
        end
    end

    // Inputs are driven 2 time units after the edge, outputs sampled 1 later.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; instr_req = 1'b1; data_req = 1'b1;
        instr_addr = 32'hDEAD_0000; data_addr = 32'hBEEF_0000;
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            n_checks++;
            if ({mem_req, instr_ack, data_ack, instr_err, data_err} !== 5'b0 ||
                mem_addr !== 32'h0 || instr_rdata !== 32'h0 || data_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_state: req/iack/dack/ierr/derr=%b addr=%h want all zero",
                         {mem_req, instr_ack, data_ack, instr_err, data_err}, mem_addr);
            end
        end
        step();
        rst = 1'b0; instr_req = 1'b0; data_req = 1'b0;
    endtask

    task automatic test_tie();
        step();
        data_req = 1'b1; data_addr = 32'h40; data_we = 1'b0; data_mask = MEM_WORD;
        data_wdata = 32'h1234; instr_req = 1'b1; instr_addr = 32'h80; mem_lat = 2;
        #1;
        n_checks++;
        if ({mem_req, instr_ack, data_ack} !== 3'b000) begin
            n_fail++; $display("FAIL tie_idle: req/iack/dack=%b want 000", {mem_req, instr_ack, data_ack});
        end
        step(); #1;
        n_checks++;
        if ({mem_req, instr_ack, data_ack} !== 3'b100 || mem_addr !== 32'h40) begin
            n_fail++; $display("FAIL tie_data_first: req/iack/dack=%b addr=%h want 100 addr 40",
                               {mem_req, instr_ack, data_ack}, mem_addr);
        end
        step(); #1;
        n_checks++;
        if ({instr_ack, data_ack, data_err} !== 3'b010 || data_rdata !== rd_fn(32'h40) || instr_rdata !== 32'h0) begin
            n_fail++; $display("FAIL tie_data_ack: iack/dack/derr=%b drdata=%h irdata=%h want 010 %h 0",
                               {instr_ack, data_ack, data_err}, data_rdata, instr_rdata, rd_fn(32'h40));
        end
        data_req = 1'b0;
        step(); #1;
        n_checks++;
        if ({mem_req, instr_ack, data_ack} !== 3'b000) begin
            n_fail++; $display("FAIL tie_gap_idle: req/iack/dack=%b want 000", {mem_req, instr_ack, data_ack});
        end
        step(); #1;
        n_checks++;
        if ({mem_req, mem_we} !== 2'b10 || mem_addr !== 32'h80 || mem_mask !== MEM_WORD || mem_wdata !== 32'h0) begin
            n_fail++; $display("FAIL tie_fetch_grant: req/we=%b addr=%h mask=%0d wdata=%h want 10 80 word 0",
                               {mem_req, mem_we}, mem_addr, mem_mask, mem_wdata);
        end
        step(); #1;
        n_checks++;
        if ({instr_ack, data_ack, instr_err} !== 3'b100 || instr_rdata !== rd_fn(32'h80) || data_rdata !== 32'h0) begin
            n_fail++; $display("FAIL tie_fetch_ack: iack/dack/ierr=%b irdata=%h drdata=%h want 100 %h 0",
                               {instr_ack, data_ack, instr_err}, instr_rdata, data_rdata, rd_fn(32'h80));
        end
        instr_req = 1'b0;
    endtask

    task automatic test_zero_wait_fetch();
        step();
        instr_req = 1'b1; instr_addr = 32'h100; mem_lat = 1;
        #1;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL zw_idle_req: mem_req=%b want 0", mem_req);
        end
        step(); #1;
        n_checks++;
        if ({mem_req, instr_ack, instr_err, data_ack} !== 4'b1100 || instr_rdata !== 32'h0050_0093 ||
            mem_addr !== 32'h100) begin
            n_fail++; $display("FAIL zw_fetch: req/iack/ierr/dack=%b rdata=%h addr=%h want 1100 00500093 100",
                               {mem_req, instr_ack, instr_err, data_ack}, instr_rdata, mem_addr);
        end
        instr_req = 1'b0;
        step(); #1;
        n_checks++;
        if ({mem_req, instr_ack, data_ack} !== 3'b000) begin
            n_fail++; $display("FAIL zw_back_idle: req/iack/dack=%b want 000", {mem_req, instr_ack, data_ack});
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_q[$];
        logic [31:0] exp_addr;
        int d_k = 0;
        int i_k = 0;
        // Both requesters stay busy: grants alternate starting with data.
        exp_q = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008};
        step();
        data_req = 1'b1; instr_req = 1'b1; data_addr = 32'h1000; instr_addr = 32'h2000;
        data_we = 1'b0; data_mask = MEM_HALF; mem_lat = 1;
        for (int t = 0; t < 5; t++) begin
            #1;
            n_checks++;
            if ({mem_req, instr_ack, data_ack} !== 3'b000) begin
                n_fail++; $display("FAIL rr_idle_%0d: req/iack/dack=%b want 000", t, {mem_req, instr_ack, data_ack});
            end
            step(); #1;
            exp_addr = exp_q.pop_front();
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== exp_addr ||
                {instr_ack, data_ack} !== (exp_addr[12] ? 2'b01 : 2'b10)) begin
                n_fail++; $display("FAIL rr_grant_%0d: req=%b addr=%h iack/dack=%b want addr %h",
                                   t, mem_req, mem_addr, {instr_ack, data_ack}, exp_addr);
            end
            if (data_ack === 1'b1) begin
                d_k++; data_addr = 32'h1000 + 32'(d_k * 4);
                if (d_k == 3) data_req = 1'b0;
            end else begin
                i_k++; instr_addr = 32'h2000 + 32'(i_k * 4);
            end
            if (t == 4) instr_req = 1'b0;
            step();
        end
    endtask

    task automatic test_byte_store();
        step();
        data_req = 1'b1; data_we = 1'b1; data_mask = MEM_BYTE; data_addr = 32'h203;
        data_wdata = 32'hAB; mem_lat = 3;
        #1;
        for (int c = 1; c <= 3; c++) begin
            step(); #1;
            n_checks++;
            if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h203 || mem_mask !== MEM_BYTE ||
                mem_wdata !== 32'hAB || {data_ack, data_err, instr_ack} !== {(c == 3), 2'b00}) begin
                n_fail++; $display("FAIL store_c%0d: req/we=%b addr=%h mask=%0d wdata=%h dack/derr/iack=%b",
                                   c, {mem_req, mem_we}, mem_addr, mem_mask, mem_wdata,
                                   {data_ack, data_err, instr_ack});
            end
        end
        data_req = 1'b0; data_we = 1'b0;
        step(); #1;
        n_checks++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL store_release: mem_req=%b want 0", mem_req);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] a;
        for (int r = 0; r < 2; r++) begin
            a = 32'h300 + 32'(r * 4);
            step();
            data_req = 1'b1; data_we = 1'b0; data_mask = MEM_WORD; data_addr = a;
            mem_lat = (r == 0) ? 0 : TO;
            #1;
            for (int c = 1; c <= TO; c++) begin
                step(); #1;
                n_checks++;
                if (c < TO) begin
                    if ({mem_req, data_ack, instr_ack} !== 3'b100) begin
                        n_fail++; $display("FAIL to%0d_wait_c%0d: req/dack/iack=%b want 100",
                                           r, c, {mem_req, data_ack, instr_ack});
                    end
                end else if ({data_ack, data_err, instr_ack} !== {1'b1, (r == 0), 1'b0} ||
                             data_rdata !== ((r == 0) ? 32'h0 : rd_fn(a))) begin
                    n_fail++; $display("FAIL to%0d_end: dack/derr/iack=%b rdata=%h want err=%0d",
                                       r, {data_ack, data_err, instr_ack}, data_rdata, (r == 0));
                end
            end
            data_req = 1'b0;
            step(); #1;
            n_checks++;
            if ({mem_req, data_ack} !== 2'b00) begin
                n_fail++; $display("FAIL to%0d_idle: req/dack=%b want 00", r, {mem_req, data_ack});
            end
        end
    endtask

    task automatic test_reset_mid();
        step();
        instr_req = 1'b1; instr_addr = 32'h500; mem_lat = 1;
        #1;
        step();
        rst = 1'b1; instr_req = 1'b0;
        #1;
        n_checks++;
        if ({instr_ack, data_ack, instr_err} !== 3'b000 || instr_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_no_ack: iack/dack/ierr=%b irdata=%h want 000 0",
                               {instr_ack, data_ack, instr_err}, instr_rdata);
        end
        step();
        rst = 1'b0; data_req = 1'b1; instr_req = 1'b1; data_addr = 32'h600; instr_addr = 32'h700;
        data_we = 1'b0; data_mask = MEM_WORD;
        #1;
        n_checks++;
        if ({mem_req, instr_ack, data_ack} !== 3'b000 || mem_addr !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_cleared: req/iack/dack=%b addr=%h want 000 0",
                               {mem_req, instr_ack, data_ack}, mem_addr);
        end
        step(); #1;
        n_checks++;
        if ({mem_req, data_ack, instr_ack} !== 3'b110 || mem_addr !== 32'h600) begin
            n_fail++; $display("FAIL rstmid_data_wins: req/dack/iack=%b addr=%h want 110 600",
                               {mem_req, data_ack, instr_ack}, mem_addr);
        end
        data_req = 1'b0;
        step();
        step(); #1;
        n_checks++;
        if ({instr_ack, data_ack} !== 2'b10 || mem_addr !== 32'h700) begin
            n_fail++; $display("FAIL rstmid_fetch_next: iack/dack=%b addr=%h want 10 700",
                               {instr_ack, data_ack}, mem_addr);
        end
        instr_req = 1'b0;
    endtask

    task automatic test_random();
        localparam int N = 30;
        logic [31:0] ia, da, dw, ea, ewd;
        logic dwe, ewe, fin_ok, fin_to;
        memory_mask_t dm, em;
        arb_port_t last;
        int ip = 0, dp = 0, i_iss = 0, d_iss = 0, i_done = 0, d_done = 0;
        int busy = 0, cyc = 0, lat = 0, budget = 0;
        ia = '0; da = '0; dw = '0; dwe = 1'b0; dm = MEM_WORD;
        step(); rst = 1'b1; instr_req = 1'b0; data_req = 1'b0;
        step(); rst = 1'b0;
        last = ARB_INSTR;
        while ((i_done < N || d_done < N) && budget < 3000) begin
            step();
            budget++;
            if (ip == 0 && i_iss < N && $urandom_range(0, 2) != 0) begin
                ip = 1; i_iss++; ia = $urandom & 32'hFFFF_FFFC;
            end
            if (dp == 0 && d_iss < N && $urandom_range(0, 2) != 0) begin
                dp = 1; d_iss++; da = $urandom; dwe = 1'($urandom_range(0, 1));
                dw = $urandom; dm = memory_mask_t'($urandom_range(0, 2));
            end
            instr_req = (ip != 0); instr_addr = ia;
            data_req = (dp != 0); data_addr = da; data_we = dwe; data_wdata = dw; data_mask = dm;
            #1;
            if (busy == 0) begin
                n_checks++;
                if ({mem_req, instr_ack, data_ack} !== 3'b000) begin
                    n_fail++; $display("FAIL rand_idle: req/iack/dack=%b want 000", {mem_req, instr_ack, data_ack});
                end
                if (ip != 0 && dp != 0) busy = (last == ARB_INSTR) ? 2 : 1;
                else if (dp != 0) busy = 2;
                else if (ip != 0) busy = 1;
                if (busy != 0) begin
                    cyc = 0; lat = $urandom_range(0, 6); mem_lat = lat;
                    last = (busy == 2) ? ARB_DATA : ARB_INSTR;
                end
            end else begin
                cyc++;
                ea  = (busy == 2) ? da : ia;
                ewe = (busy == 2) ? dwe : 1'b0;
                ewd = (busy == 2) ? dw : 32'h0;
                em  = (busy == 2) ? dm : MEM_WORD;
                fin_ok = (lat != 0 && cyc == lat);
                fin_to = !fin_ok && (cyc == TO);
                n_checks++;
                if (mem_req !== 1'b1 || mem_addr !== ea || mem_we !== ewe || mem_wdata !== ewd || mem_mask !== em) begin
                    n_fail++; $display("FAIL rand_bus: req=%b addr=%h we=%b wdata=%h mask=%0d want addr=%h we=%b wdata=%h mask=%0d",
                                       mem_req, mem_addr, mem_we, mem_wdata, mem_mask, ea, ewe, ewd, em);
                end
                n_checks++;
                if ({instr_ack, data_ack} !== {(busy == 1) && (fin_ok || fin_to), (busy == 2) && (fin_ok || fin_to)}) begin
                    n_fail++; $display("FAIL rand_ack: iack/dack=%b port=%0d cyc=%0d lat=%0d",
                                       {instr_ack, data_ack}, busy, cyc, lat);
                end
                n_checks++;
                if (busy == 1 ? (data_rdata !== 32'h0 || data_err !== 1'b0) : (instr_rdata !== 32'h0 || instr_err !== 1'b0)) begin
                    n_fail++; $display("FAIL rand_other_port: irdata=%h ierr=%b drdata=%h derr=%b port=%0d",
                                       instr_rdata, instr_err, data_rdata, data_err, busy);
                end
                if (fin_ok || fin_to) begin
                    n_checks++;
                    if ((busy == 1 ? {instr_err, instr_rdata} : {data_err, data_rdata}) !== {fin_to, fin_ok ? rd_fn(ea) : 32'h0}) begin
                        n_fail++; $display("FAIL rand_resp: port=%0d err i/d=%b/%b rdata i/d=%h/%h want err=%b",
                                           busy, instr_err, data_err, instr_rdata, data_rdata, fin_to);
                    end
                    if (busy == 1) begin ip = 0; i_done++; end
                    else begin dp = 0; d_done++; end
                    busy = 0;
                end
            end
        end
        n_checks++;
        if (i_done < N || d_done < N) begin
            n_fail++; $display("FAIL rand_budget: done instr=%0d data=%0d want %0d each", i_done, d_done, N);
        end
        instr_req = 1'b0; data_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tie();
        test_zero_wait_fetch();
        test_round_robin();
        test_byte_store();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the CPU's single-ported memory between the instruction-fetch port and the data (load/store) port driven by `control_unit` outputs (`memory_we`, `memory_mask`). It accepts one request at a time through a req/ack handshake and registers the granted request onto the memory bus. Ties are resolved round-robin, with data first after reset. A watchdog aborts transactions the memory never completes.

## Interface
- `TIMEOUT`, default 16: memory-response watchdog in cycles; 0 disables it.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `instr_req`  in  1  fetch request; held stable until `instr_ack`.
- `instr_addr`  in  32  fetch address (word access).
- `instr_ack`  out  1  fetch complete; one-cycle pulse.
- `instr_rdata`  out  32  fetch data; valid only with `instr_ack`.
- `instr_err`  out  1  fetch timed out; valid only with `instr_ack`.
- `data_req`  in  1  load/store request; held stable until `data_ack`.
- `data_addr`  in  32  load/store address.
- `data_we`  in  1  1 = store.
- `data_wdata`  in  32  store data.
- `data_mask`  in  memory_mask_t  access size.
- `data_ack`  out  1  load/store complete; one-cycle pulse.
- `data_rdata`  out  32  load data; valid only with `data_ack`.
- `data_err`  out  1  load/store timed out; valid only with `data_ack`.
- `mem_req`  out  1  registered request to memory.
- `mem_addr`  out  32  registered address.
- `mem_we`  out  1  registered write enable.
- `mem_wdata`  out  32  registered write data.
- `mem_mask`  out  memory_mask_t  registered access size; word-sized for fetches.
- `mem_ready`  in  1  memory done; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  memory read data.

## Operation
- FSM states: IDLE, BUSY_INSTR, BUSY_DATA.
- Priority register `last_grant` (INSTR/DATA) resets to INSTR.
- IDLE:
  - Only `data_req` high: go to BUSY_DATA.
  - Only `instr_req` high: go to BUSY_INSTR.
  - Both high: grant the port not equal to `last_grant`.
  - On the grant edge, capture the granted port's addr/we/wdata/mask into the `mem_*` registers, set `mem_req`=1, update `last_grant`, clear the watchdog.
- BUSY_x with `mem_ready`=1:
  - `x_ack`=1 combinationally.
  - `x_rdata`=`mem_rdata`, `x_err`=0.
  - Next edge: `mem_req`=0, state IDLE.
- BUSY_x with `mem_ready`=0: the watchdog increments each cycle.
  - When it equals `TIMEOUT` (and `TIMEOUT`≠0): `x_ack`=1, `x_err`=1, `x_rdata`=0.
  - Next edge: IDLE, `mem_req`=0.
  - A `mem_ready` arriving in that same cycle wins: normal ack, err=0.
- A fetch always drives `mem_we`=0, `mem_wdata`=0, and a word-sized `mem_mask`.
- Acks and rdata are never asserted for the port that is not granted. Both acks are 0 in IDLE.
- Requests arriving while BUSY wait in IDLE for arbitration. None are dropped or merged.
- `rst` (at any time, including mid-transaction): next edge gives state IDLE, `mem_req`=0, `mem_*`=0, `last_grant`=INSTR, watchdog 0.
  - An in-flight transaction is abandoned with no ack.
  - All ack/err/rdata outputs are 0 while `rst` is high.

## Timing
- Grant latency: request seen in IDLE at cycle N, `mem_req` high at N+1.
- A zero-wait memory (`mem_ready` at N+1) gives ack at N+1 and IDLE at N+2.
- Requesters drop or change `req` in the cycle after ack. A still-high `req` in IDLE is a new request.
- Back-to-back throughput: one transaction per 2 cycles minimum, because IDLE costs one cycle.
- Watchdog width: `$clog2(TIMEOUT+1)`.
- Timeout ack fires in the `TIMEOUT`-th BUSY cycle, counting the first `mem_req` cycle as 1.

## Structure
- Add `arb_state_t` {IDLE, BUSY_INSTR, BUSY_DATA} and `arb_port_t` {ARB_INSTR, ARB_DATA} to `cpu_types`, beside `memory_mask_t`.
- Sub-module `mem_timeout_counter`:
  - Inputs: `clk`, `rst`, `clear`, `enable`.
  - Output: `expired`.
  - Parameter: `TIMEOUT`; `TIMEOUT`=0 ties `expired` low.
- The FSM, capture registers and ack muxing live in `memory_arbiter`.

## Test plan
- Zero-wait fetch: `instr_req` with addr 0x100; memory returns 0x00500093 when `mem_req` is seen. Expect `mem_req` one cycle after the request, `instr_ack` in the same cycle as `mem_ready`, rdata 0x00500093.
- Tie after reset: both requests in the same cycle. Expect data served first, fetch granted on the next IDLE, no ack crossover.
- Round-robin: `data_req` held high for 3 transactions while `instr_req` stays high. Expect grants D,I,D,I,D; fetch is never starved.
- Byte store: `data_we`=1, byte mask, addr 0x203, wdata 0xAB. Expect `mem_we`=1, byte mask, `mem_addr`=0x203 held stable until `mem_ready`; `data_err`=0.
- Timeout with `TIMEOUT`=4: `mem_ready` never asserted. Expect `data_ack`=1, `data_err`=1, rdata 0 in BUSY cycle 4, then IDLE. Repeat with `mem_ready` in cycle 4: expect err=0.
- Reset mid-op: assert `rst` during BUSY_INSTR. Expect no ack, `mem_req`=0 next cycle, and data wins the next tie.
